// File: rtl/decoder_2to4.sv
// Registered (or combinational) 2-to-4 line decoder with enable, polarity
// option, a valid flag that tracks the enable, and a sticky one-hot error monitor.
module decoder_2to4 #(
  parameter bit REGISTERED = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic E,
  input  logic I0,
  input  logic I1,
  output logic A0,
  output logic A1,
  output logic A2,
  output logic A3,
  output logic valid,
  output logic err
);

  function automatic logic [3:0] decode(input logic en, input logic [1:0] sel);
    logic [3:0] d;
    d = 4'b0000;
    if (en) begin
      case (sel)
        2'b00:   d = 4'b0001;
        2'b01:   d = 4'b0010;
        2'b10:   d = 4'b0100;
        2'b11:   d = 4'b1000;
        default: d = 4'b0000;
      endcase
    end
    return d;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  logic [3:0] dec_d;
  logic       vld_d;
  logic [3:0] dec_out;
  logic       vld_out;
  logic       err_d;
  logic       err_q;

  always_comb begin
    dec_d = decode(E, {I1, I0});
    vld_d = E;
  end

  // Output stage: either a capture register or a straight pass-through.
  if (REGISTERED) begin : g_reg
    logic [3:0] dec_q;
    logic       vld_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dec_q <= 4'b0000;
        vld_q <= 1'b0;
      end else begin
        dec_q <= dec_d;
        vld_q <= vld_d;
      end
    end

    assign dec_out = dec_q;
    assign vld_out = vld_q;
  end else begin : g_comb
    assign dec_out = dec_d;
    assign vld_out = vld_d;
  end

  // The monitor watches the vector actually presented, before polarity inversion.
  always_comb begin
    err_d = err_q;
    if (vld_out) begin
      if (!is_onehot(dec_out)) err_d = 1'b1;
    end else begin
      if (dec_out != 4'b0000) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  always_comb begin
    {A3, A2, A1, A0} = ACTIVE_LOW ? ~dec_out : dec_out;
    valid            = vld_out;
    err              = err_q;
  end

endmodule

// File: tb/tb_decoder_2to4.sv
// Bench for decoder_2to4: one instance per parameter combination, driven from a
// shared vector table, with registered results checked through a scoreboard queue.
module tb_decoder_2to4;

  logic clk;
  logic rst;
  logic E, I0, I1;

  logic r_a0, r_a1, r_a2, r_a3, r_v, r_e;   // REGISTERED=1 ACTIVE_LOW=0
  logic l_a0, l_a1, l_a2, l_a3, l_v, l_e;   // REGISTERED=1 ACTIVE_LOW=1
  logic c_a0, c_a1, c_a2, c_a3, c_v, c_e;   // REGISTERED=0 ACTIVE_LOW=0
  logic k_a0, k_a1, k_a2, k_a3, k_v, k_e;   // REGISTERED=0 ACTIVE_LOW=1

  decoder_2to4 #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b0)) u_reg (
    .clk(clk), .rst(rst), .E(E), .I0(I0), .I1(I1),
    .A0(r_a0), .A1(r_a1), .A2(r_a2), .A3(r_a3), .valid(r_v), .err(r_e));

  decoder_2to4 #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b1)) u_reg_al (
    .clk(clk), .rst(rst), .E(E), .I0(I0), .I1(I1),
    .A0(l_a0), .A1(l_a1), .A2(l_a2), .A3(l_a3), .valid(l_v), .err(l_e));

  decoder_2to4 #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b0)) u_comb (
    .clk(clk), .rst(rst), .E(E), .I0(I0), .I1(I1),
    .A0(c_a0), .A1(c_a1), .A2(c_a2), .A3(c_a3), .valid(c_v), .err(c_e));

  decoder_2to4 #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b1)) u_comb_al (
    .clk(clk), .rst(rst), .E(E), .I0(I0), .I1(I1),
    .A0(k_a0), .A1(k_a1), .A2(k_a2), .A3(k_a3), .valid(k_v), .err(k_e));

  typedef struct {
    logic       e;
    logic [1:0] sel;
    logic [3:0] exp_a;
    logic       exp_v;
  } vec_t;

  vec_t vecs[10];
  vec_t sb_q[$];
  int   n_tests;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one vector on the falling edge, check the combinational instances at
  // once, then check the registered instances just after the next rising edge.
  task automatic apply(input vec_t v);
    vec_t exp;
    @(negedge clk);
    E  = v.e;
    {I1, I0} = v.sel;
    sb_q.push_back(v);
    #1;
    chk("comb_A",    {c_a3, c_a2, c_a1, c_a0}, v.exp_a);
    chk("comb_valid", {3'b000, c_v}, {3'b000, v.exp_v});
    chk("comb_al_A", {k_a3, k_a2, k_a1, k_a0}, ~v.exp_a);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 4'd1, 4'd0);
    end else begin
      exp = sb_q.pop_front();
      chk("reg_A",     {r_a3, r_a2, r_a1, r_a0}, exp.exp_a);
      chk("reg_valid", {3'b000, r_v}, {3'b000, exp.exp_v});
      chk("reg_al_A",  {l_a3, l_a2, l_a1, l_a0}, ~exp.exp_a);
      chk("reg_al_valid", {3'b000, l_v}, {3'b000, exp.exp_v});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{1'b0, 2'b00, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 2'b01, 4'b0010, 1'b1};
    vecs[2] = '{1'b1, 2'b10, 4'b0100, 1'b1};
    vecs[3] = '{1'b0, 2'b11, 4'b0000, 1'b0};
    vecs[4] = '{1'b1, 2'b00, 4'b0001, 1'b1};
    vecs[5] = '{1'b1, 2'b01, 4'b0010, 1'b1};
    vecs[6] = '{1'b1, 2'b10, 4'b0100, 1'b1};
    vecs[7] = '{1'b1, 2'b11, 4'b1000, 1'b1};
    vecs[8] = '{1'b0, 2'b01, 4'b0000, 1'b0};
    vecs[9] = '{1'b1, 2'b11, 4'b1000, 1'b1};

    rst = 1'b1;
    E   = 1'b0;
    I0  = 1'b0;
    I1  = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_A",     {r_a3, r_a2, r_a1, r_a0}, 4'b0000);
    chk("rst_valid", {3'b000, r_v}, 4'b0000);
    chk("rst_err",   {r_e, l_e, c_e, k_e}, 4'b0000);
    chk("rst_al_A",  {l_a3, l_a2, l_a1, l_a0}, 4'b1111);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply(vecs[i]);
    chk("err_after_table", {r_e, l_e, c_e, k_e}, 4'b0000);

    // Asynchronous reset between edges while the registered output shows A2.
    apply('{1'b1, 2'b10, 4'b0100, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_A",     {r_a3, r_a2, r_a1, r_a0}, 4'b0000);
    chk("midrst_valid", {3'b000, r_v}, 4'b0000);
    chk("midrst_al_A",  {l_a3, l_a2, l_a1, l_a0}, 4'b1111);
    chk("midrst_comb_A", {c_a3, c_a2, c_a1, c_a0}, 4'b0100);
    @(negedge clk);
    {I1, I0} = 2'b11;
    @(posedge clk);
    #1;
    chk("held_rst_A", {r_a3, r_a2, r_a1, r_a0}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("released_pre_edge_A", {r_a3, r_a2, r_a1, r_a0}, 4'b0000);
    chk("released_pre_edge_valid", {3'b000, r_v}, 4'b0000);
    @(posedge clk);
    #1;
    chk("first_after_rst_A", {r_a3, r_a2, r_a1, r_a0}, 4'b1000);
    chk("first_after_rst_valid", {3'b000, r_v}, 4'b0001);
    chk("first_after_rst_al_A", {l_a3, l_a2, l_a1, l_a0}, 4'b0111);

    // Back-to-back traffic after the reset, then a final error check.
    apply('{1'b1, 2'b10, 4'b0100, 1'b1});
    apply('{1'b0, 2'b10, 4'b0000, 1'b0});
    apply('{1'b1, 2'b00, 4'b0001, 1'b1});
    chk("err_final", {r_e, l_e, c_e, k_e}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
